// File: rtl/y86_dbg_pkg.sv
// rtl/y86_dbg_pkg.sv - shared Y86-64 debug types and constants (frame length depends on REGDUMP_CKSUM_EN)
package y86_dbg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_CNT,
        ST_DATA,
        ST_CKSUM
    } dump_state_e;

    localparam int         DEF_NUM_REGS  = 15;
    localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;

    // Architectural register numbering, shared with the register file
    localparam int RAX = 0;
    localparam int RCX = 1;
    localparam int RDX = 2;
    localparam int RBX = 3;
    localparam int RSP = 4;
    localparam int RBP = 5;
    localparam int RSI = 6;
    localparam int RDI = 7;
    localparam int R8  = 8;
    localparam int R9  = 9;
    localparam int R10 = 10;
    localparam int R11 = 11;
    localparam int R12 = 12;
    localparam int R13 = 13;
    localparam int R14 = 14;

`ifdef REGDUMP_CKSUM_EN
    localparam int CKSUM_BYTES = 1;
`else
    localparam int CKSUM_BYTES = 0;
`endif

    // Sync byte + count byte + 8 bytes per register + optional checksum
    localparam int FRAME_LEN = 2 + 8 * DEF_NUM_REGS + CKSUM_BYTES;

endpackage

// File: rtl/y86_byte_serializer.sv
// rtl/y86_byte_serializer.sv - streams one 64-bit word as 8 little-endian bytes
module y86_byte_serializer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] word_i,
    input  logic        load_i,
    input  logic        tready_i,
    output logic [7:0]  tdata_o,
    output logic        word_done_o
);

    logic [63:0] word_q;
    logic [2:0]  cnt_q;
    logic        valid_q;

    // The current byte is always the low byte of the shift register
    assign tdata_o     = word_q[7:0];
    assign word_done_o = valid_q && tready_i && (cnt_q == 3'd7);

    // Load a new word, or shift one byte out per accepted transfer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q  <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else if (load_i) begin
            word_q  <= word_i;
            cnt_q   <= '0;
            valid_q <= 1'b1;
        end else if (valid_q && tready_i) begin
            word_q <= {8'h00, word_q[63:8]};
            cnt_q  <= cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
                valid_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/y86_regfile_dumper.sv
// rtl/y86_regfile_dumper.sv - snapshots register taps and streams a framed dump (REGDUMP_CKSUM_EN adds XOR byte)
module y86_regfile_dumper
    import y86_dbg_pkg::*;
#(
    parameter int         NUM_REGS  = DEF_NUM_REGS,
    parameter logic [7:0] SYNC_BYTE = DEF_SYNC_BYTE
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [64*NUM_REGS-1:0] regs_flat,
    output logic [7:0]             tx_data,
    output logic                   tx_valid,
    input  logic                   tx_ready,
    output logic                   busy,
    output logic                   done
);

    localparam int            IW       = $clog2(NUM_REGS);
    localparam logic [7:0]    CNT_BYTE = 8'(NUM_REGS);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_REGS - 1);

    dump_state_e   state_q;
    logic [63:0]   snap_q [NUM_REGS];
    logic [IW-1:0] reg_idx_q;
    logic [7:0]    ctl_byte_q;
    logic          valid_q;
    logic          busy_q;
    logic          done_q;
`ifdef REGDUMP_CKSUM_EN
    logic [7:0]    cksum_q;
`endif

    logic          xfer;
    logic          ser_ready;
    logic          ser_load;
    logic          ser_word_done;
    logic [7:0]    ser_byte;
    logic [IW-1:0] load_idx;

    assign xfer      = valid_q && tx_ready;
    assign ser_ready = tx_ready && (state_q == ST_DATA);
    // Reload the serializer when leaving CNT and on each word boundary
    // except the last, so data bytes flow without a bubble
    assign ser_load  = xfer && ((state_q == ST_CNT) ||
                                ((state_q == ST_DATA) && ser_word_done && (reg_idx_q != LAST_IDX)));
    assign load_idx  = (state_q == ST_CNT) ? '0 : reg_idx_q + 1'b1;

    y86_byte_serializer u_ser (
        .clk         (clk),
        .rst_n       (rst_n),
        .word_i      (snap_q[load_idx]),
        .load_i      (ser_load),
        .tready_i    (ser_ready),
        .tdata_o     (ser_byte),
        .word_done_o (ser_word_done)
    );

    assign tx_data  = (state_q == ST_DATA) ? ser_byte : ctl_byte_q;
    assign tx_valid = valid_q;
    assign busy     = busy_q;
    assign done     = done_q;

    // Frame sequencer: header, count, data words, optional checksum
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            reg_idx_q  <= '0;
            ctl_byte_q <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                snap_q[i] <= '0;
            end
`ifdef REGDUMP_CKSUM_EN
            cksum_q    <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        for (int i = 0; i < NUM_REGS; i++) begin
                            snap_q[i] <= regs_flat[64*i +: 64];
                        end
`ifdef REGDUMP_CKSUM_EN
                        cksum_q    <= '0;
`endif
                        ctl_byte_q <= SYNC_BYTE;
                        valid_q    <= 1'b1;
                        busy_q     <= 1'b1;
                        state_q    <= ST_HDR;
                    end
                end
                ST_HDR: begin
                    if (xfer) begin
                        ctl_byte_q <= CNT_BYTE;
                        state_q    <= ST_CNT;
                    end
                end
                ST_CNT: begin
                    if (xfer) begin
`ifdef REGDUMP_CKSUM_EN
                        cksum_q   <= cksum_q ^ CNT_BYTE;
`endif
                        reg_idx_q <= '0;
                        state_q   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (xfer) begin
`ifdef REGDUMP_CKSUM_EN
                        cksum_q <= cksum_q ^ ser_byte;
`endif
                        if (ser_word_done) begin
                            if (reg_idx_q == LAST_IDX) begin
`ifdef REGDUMP_CKSUM_EN
                                ctl_byte_q <= cksum_q ^ ser_byte;
                                state_q    <= ST_CKSUM;
`else
                                valid_q    <= 1'b0;
                                busy_q     <= 1'b0;
                                done_q     <= 1'b1;
                                state_q    <= ST_IDLE;
`endif
                            end else begin
                                reg_idx_q <= reg_idx_q + 1'b1;
                            end
                        end
                    end
                end
`ifdef REGDUMP_CKSUM_EN
                ST_CKSUM: begin
                    if (xfer) begin
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                end
`endif
                default: begin
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
